trace_capture_buffer: RTL and testbench

Synthesizable hardware line-trace recorder, the successor to the simulation-only trace helper.
- Records per-cycle multi-channel trace samples, each tagged with a cycle stamp, into a circular buffer of DEPTH entries.
- Holds a pre-trigger history, then captures a programmable post-trigger window.
- Drains oldest-first over a val/rdy stream to a host or logger.

---
 rtl/trace_capture_pkg.sv | 19 +
 rtl/trace_capture_ram.sv | 25 ++
 rtl/trace_capture_buffer.sv | 144 ++++++++++++++
 tb/tb_trace_capture_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// Shared types and sizing helpers for the trace capture buffer.
package trace_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int entry_width(input int cwidth, input int nchannels, input int dwidth);
    return cwidth + nchannels + nchannels * dwidth;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// Trace storage: flop array with one synchronous write port and one
// combinational read port; contents are intentionally not reset.
module trace_capture_ram
  import trace_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [ptr_width(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [ptr_width(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Line-trace recorder: circular pre-trigger history, programmable post-trigger
// window, oldest-first val/rdy drain. TRACE_CAPTURE_DROP_CNT_EN adds drop_cnt.
module trace_capture_buffer
  import trace_capture_pkg::*;
#(
  parameter int NCHANNELS = 4,
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 16,
  parameter int CWIDTH    = 32
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [3:0]                                 level,
  input  logic [NCHANNELS-1:0]                       chan_val,
  input  logic [NCHANNELS*DWIDTH-1:0]                chan_data,
  input  logic                                       arm,
  input  logic                                       trig,
  input  logic [$clog2(DEPTH):0]                     post_len,
  output logic [CWIDTH-1:0]                          cycles,
  output logic                                       done,
  output logic                                       rd_val,
  input  logic                                       rd_rdy,
  output logic [CWIDTH+NCHANNELS+NCHANNELS*DWIDTH-1:0] rd_msg
`ifdef TRACE_CAPTURE_DROP_CNT_EN
  ,output logic [CWIDTH-1:0]                         drop_cnt
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int EW = entry_width(CWIDTH, NCHANNELS, DWIDTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] MAX_POST = PW'(DEPTH - 1);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW-1:0] post_cnt;

  logic          wr_en;
  logic [PW:0]   count_wr;
  logic [PW-1:0] wr_ptr_nx;
  logic [PW-1:0] post_load;
  logic          enter_drain;
  logic [EW-1:0] wr_data;

  always_comb begin
    wr_en     = (state == ARMED || state == POST) && (level != 4'd0) && (|chan_val);
    count_wr  = (wr_en && count != FULL) ? count + (PW+1)'(1) : count;
    wr_ptr_nx = wr_en ? wr_ptr + PW'(1) : wr_ptr;
    // Clamping keeps the trigger entry from being overwritten by the post window.
    post_load = (post_len > (PW+1)'(DEPTH - 1)) ? MAX_POST : post_len[PW-1:0];
    enter_drain = (state == ARMED && trig && post_load == '0) ||
                  (state == POST && wr_en && post_cnt == PW'(1));
    wr_data   = {cycles, chan_val, chan_data};
  end

`ifdef TRACE_CAPTURE_DROP_CNT_EN
  logic [CWIDTH-1:0] drop_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (state == IDLE && arm) begin
      drop_q <= '0;
    end else if (state == ARMED && wr_en && count == FULL && drop_q != '1) begin
      drop_q <= drop_q + CWIDTH'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cycles   <= '0;
      done     <= 1'b0;
      rd_val   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      cycles <= cycles + CWIDTH'(1);
      if (wr_en) begin
        wr_ptr <= wr_ptr_nx;
        count  <= count_wr;
      end
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= ARMED;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        ARMED: begin
          if (trig) begin
            post_cnt <= post_load;
            state    <= POST;
          end
        end
        POST: begin
          if (wr_en) post_cnt <= post_cnt - PW'(1);
        end
        DRAIN: begin
          if (count == '0) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (rd_val && rd_rdy) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - (PW+1)'(1);
            if (count == (PW+1)'(1)) begin
              state  <= IDLE;
              done   <= 1'b0;
              rd_val <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Overrides the ARMED/POST branches above on the cycle the window closes.
      if (enter_drain) begin
        state  <= DRAIN;
        done   <= 1'b1;
        rd_val <= (count_wr != '0);
        rd_ptr <= wr_ptr_nx - count_wr[PW-1:0];
      end
    end
  end

  trace_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_msg)
  );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer (DEPTH=8, 2 channels x 8 bits, 16-bit stamps).
module tb_trace_capture_buffer;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int PLW   = 4;
  localparam int EW    = CW + NCH + NCH * DW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        level = 4'd0;
  logic [NCH-1:0]    chan_val = '0;
  logic [NCH*DW-1:0] chan_data = '0;
  logic              arm = 1'b0;
  logic              trig = 1'b0;
  logic [PLW-1:0]    post_len = '0;
  logic [CW-1:0]     cycles;
  logic              done;
  logic              rd_val;
  logic              rd_rdy = 1'b0;
  logic [EW-1:0]     rd_msg;
`ifdef TRACE_CAPTURE_DROP_CNT_EN
  logic [CW-1:0]     drop_cnt;
`endif

  trace_capture_buffer #(
    .NCHANNELS (NCH),
    .DWIDTH    (DW),
    .DEPTH     (DEPTH),
    .CWIDTH    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .level     (level),
    .chan_val  (chan_val),
    .chan_data (chan_data),
    .arm       (arm),
    .trig      (trig),
    .post_len  (post_len),
    .cycles    (cycles),
    .done      (done),
    .rd_val    (rd_val),
    .rd_rdy    (rd_rdy),
    .rd_msg    (rd_msg)
`ifdef TRACE_CAPTURE_DROP_CNT_EN
    ,.drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int mstate = 0;   // 0 idle, 1 armed, 2 post, 3 drain
  int mpost = 0;
  int mcyc = 0;
  int mdrops = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    mcyc++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mstate = 0;
    mpost = 0;
    mcyc = 0;
    mdrops = 0;
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b1;
    #1;
    checks++;
    if (rd_val !== 1'b0) begin failures++; $display("FAIL %s_rd_val got=%b exp=0", name, rd_val); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL %s_done got=%b exp=0", name, done); end
    checks++;
    if (cycles !== '0) begin failures++; $display("FAIL %s_cycles got=%0d exp=0", name, cycles); end
`ifdef TRACE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== '0) begin failures++; $display("FAIL %s_drop_cnt got=%0d exp=0", name, drop_cnt); end
`endif
    model_reset();
    rd_rdy = 1'b0;
    arm = 1'b0;
    trig = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one cycle of stimulus and advances the model; expected entries are
  // pushed to the scoreboard as the corresponding sample is driven.
  task automatic drive(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d,
                       input logic [3:0] lv, input logic a, input logic t, input int pl);
    bit wr;
    int p;
    chan_val = v;
    chan_data = d;
    level = lv;
    arm = a;
    trig = t;
    post_len = PLW'(pl);
    wr = (mstate == 1 || mstate == 2) && lv != 4'd0 && v != '0;
    if (wr) begin
      exp_q.push_back({CW'(mcyc), v, d});
      if (exp_q.size() > DEPTH) begin
        void'(exp_q.pop_front());
        if (mstate == 1 && mdrops < 65535) mdrops++;
      end
    end
    case (mstate)
      0: if (a) begin mstate = 1; exp_q.delete(); mdrops = 0; end
      1: if (t) begin
           p = (pl > DEPTH - 1) ? DEPTH - 1 : pl;
           if (p == 0) mstate = 3;
           else begin mpost = p; mstate = 2; end
         end
      2: if (wr) begin mpost--; if (mpost == 0) mstate = 3; end
      default: ;
    endcase
    tick();
    arm = 1'b0;
    trig = 1'b0;
    checks++;
    if (cycles !== CW'(mcyc)) begin failures++; $display("FAIL cycles got=%0d exp=%0d", cycles, mcyc); end
    if (mstate != 3) begin
      checks++;
      if (done !== 1'b0 || rd_val !== 1'b0) begin
        failures++;
        $display("FAIL early_drain done=%b rd_val=%b exp=0/0 at cyc %0d", done, rd_val, mcyc);
      end
    end
  endtask

  task automatic drain_check(input string name, input int rdy_pct, output int nread,
                             output logic [CW-1:0] first_stamp);
    logic [EW-1:0] prev;
    bit stalled;
    int guard;
    stalled = 0;
    guard = 0;
    nread = 0;
    prev = '0;
    first_stamp = '0;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s_done_entry got=%b exp=1", name, done); end
    if (exp_q.size() == 0) begin
      checks++;
      if (rd_val !== 1'b0) begin failures++; $display("FAIL %s_empty_rd_val got=%b exp=0", name, rd_val); end
      tick();
    end
    first_stamp = rd_msg[EW-1 -: CW];
    while (exp_q.size() > 0) begin
      guard++;
      if (guard > 400) begin
        failures++;
        $display("FAIL %s_timeout left=%0d exp=0", name, exp_q.size());
        exp_q.delete();
        break;
      end
      checks++;
      if (rd_val !== 1'b1 || done !== 1'b1) begin
        failures++;
        $display("FAIL %s_valid rd_val=%b done=%b exp=1/1", name, rd_val, done);
      end
      checks++;
      if (rd_msg !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_entry got=%h exp=%h", name, rd_msg, exp_q[0]);
      end
      if (stalled) begin
        checks++;
        if (rd_msg !== prev) begin failures++; $display("FAIL %s_stable got=%h exp=%h", name, rd_msg, prev); end
      end
      prev = rd_msg;
      rd_rdy = ($urandom_range(99) < rdy_pct);
      stalled = !rd_rdy;
      tick();
      if (!stalled) begin
        void'(exp_q.pop_front());
        nread++;
      end
    end
    rd_rdy = 1'b0;
    checks++;
    if (done !== 1'b0 || rd_val !== 1'b0) begin
      failures++;
      $display("FAIL %s_exit done=%b rd_val=%b exp=0/0", name, done, rd_val);
    end
    mstate = 0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    tick(); tick(); tick();
    checks++;
    if (cycles !== 16'd3) begin failures++; $display("FAIL reset_count got=%0d exp=3", cycles); end
  endtask

  task automatic test_basic();
    int n;
    logic [CW-1:0] fs;
    logic [7:0] c;
    apply_reset("basic_reset");
    for (int i = 0; i < 40 && mstate != 3; i++) begin
      c = mcyc[7:0];
      drive(2'b11, {c, c}, 4'd1, mcyc == 2, mcyc == 20, 3);
    end
    drain_check("basic", 100, n, fs);
    checks++;
    if (n != 8) begin failures++; $display("FAIL basic_count got=%0d exp=8", n); end
    checks++;
    if (fs !== 16'd16) begin failures++; $display("FAIL basic_first_stamp got=%0d exp=16", fs); end
  endtask

  task automatic test_wrap();
    int n;
    logic [CW-1:0] fs;
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 30; i++) drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b1, 0);
`ifdef TRACE_CAPTURE_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd23) begin failures++; $display("FAIL wrap_drop_cnt got=%0d exp=23", drop_cnt); end
`endif
    drain_check("wrap", 100, n, fs);
    checks++;
    if (n != 8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", n); end
  endtask

  task automatic test_sparse();
    int n;
    int lvl0;
    logic [CW-1:0] fs;
    logic [NCH-1:0] pat [3];
    logic [NCH-1:0] v;
    logic [3:0] lv;
    pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b10;
    lvl0 = 0;
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 60 && mstate != 3; i++) begin
      v = pat[i % 3];
      lv = 4'd3;
      if (mstate == 2 && v != '0 && lvl0 < 2) begin lv = 4'd0; lvl0++; end
      drive(v, 16'($urandom), lv, 1'b0, i == 9, 4);
    end
    drain_check("sparse", 100, n, fs);
    checks++;
    if (n != 8) begin failures++; $display("FAIL sparse_count got=%0d exp=8", n); end
  endtask

  task automatic test_back_to_back_backpressure();
    int n;
    logic [CW-1:0] fs;
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) drive(2'($urandom_range(1, 3)), 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20 && mstate != 3; i++)
      drive(2'b11, 16'($urandom), 4'd1, 1'b0, i == 0, 2);
    drain_check("backpressure", 30, n, fs);
    checks++;
    if (n != 8) begin failures++; $display("FAIL backpressure_count got=%0d exp=8", n); end
  endtask

  task automatic test_boundaries();
    int n;
    int tstamp;
    logic [CW-1:0] fs;
    // arm and trig together: armed only, the trigger is lost
    drive(2'b00, '0, 4'd1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 5; i++) drive(2'b10, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    drive(2'b00, '0, 4'd1, 1'b0, 1'b1, 0);
    drain_check("armtrig", 100, n, fs);
    checks++;
    if (n != 5) begin failures++; $display("FAIL armtrig_count got=%0d exp=5", n); end
    // empty buffer at trigger
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    drive(2'b00, '0, 4'd1, 1'b0, 1'b1, 0);
    drain_check("empty", 100, n, fs);
    // post_len beyond DEPTH-1 clamps to DEPTH-1
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(2'b01, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    tstamp = mcyc;
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b1, 15);
    for (int i = 0; i < 20 && mstate != 3; i++) drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 15);
    drain_check("clamp", 100, n, fs);
    checks++;
    if (n != 8) begin failures++; $display("FAIL clamp_count got=%0d exp=8", n); end
    checks++;
    if (fs !== CW'(tstamp)) begin failures++; $display("FAIL clamp_first_stamp got=%0d exp=%0d", fs, tstamp); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [CW-1:0] fs;
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b1, 5);
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 5);
    apply_reset("reset_post");
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b1, 1);
    drive(2'b11, 16'($urandom), 4'd1, 1'b0, 1'b0, 1);
    checks++;
    if (done !== 1'b1 || rd_val !== 1'b1) begin
      failures++;
      $display("FAIL mid_drain_entry done=%b rd_val=%b exp=1/1", done, rd_val);
    end
    rd_rdy = 1'b1;
    tick(); tick();
    apply_reset("reset_drain");
    drive(2'b00, '0, 4'd1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) drive(2'b01, 16'($urandom), 4'd1, 1'b0, 1'b0, 0);
    drive(2'b10, 16'($urandom), 4'd1, 1'b0, 1'b1, 0);
    drain_check("clean", 100, n, fs);
    checks++;
    if (n != 4) begin failures++; $display("FAIL clean_count got=%0d exp=4", n); end
    checks++;
    if (fs !== 16'd1) begin failures++; $display("FAIL clean_first_stamp got=%0d exp=1", fs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sparse();
    test_back_to_back_backpressure();
    test_boundaries();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
